// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for serial_subtractor.
// The V port exists only when SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int data_width = 8
);
  logic                  start;
  logic [data_width-1:0] A;
  logic [data_width-1:0] B;
  logic                  B_in;
  logic                  busy;
  logic                  done;
  logic [data_width-1:0] Diff;
  logic                  B_out;
`ifdef SUB_OVERFLOW_EN
  logic                  V;
`endif

  // Requester side: drives the operands, observes the result.
  modport master (
    output start, A, B, B_in,
    input  busy, done, Diff, B_out
`ifdef SUB_OVERFLOW_EN
    , input V
`endif
  );

  // Subtractor side.
  modport slave (
    input  start, A, B, B_in,
    output busy, done, Diff, B_out
`ifdef SUB_OVERFLOW_EN
    , output V
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - B_in, one bit per clock, LSB first.
// A single full-subtractor cell walks the borrow over data_width cycles.
// Optional signed-overflow output V is built when SUB_OVERFLOW_EN is defined.
module serial_subtractor #(
  parameter int data_width = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int cnt_w = $clog2(data_width) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_next;
  logic [data_width-1:0] a_sr, b_sr, d_sr;
  logic [data_width-1:0] diff_q;
  logic                  bw, bout_q;
  logic [cnt_w-1:0]      cnt;
  logic                  busy_c, done_c;
  logic                  accept, last_bit;
  logic                  a, b, d, bw_next;
`ifdef SUB_OVERFLOW_EN
  logic                  a_msb, b_msb, v_q;
`endif

  // start is honoured only outside RUN; a re-request mid-operation is dropped.
  assign accept   = bus.start && (state != RUN);
  assign last_bit = (cnt == cnt_w'(data_width - 1));

  // Full-subtractor cell on the current LSBs.
  assign a       = a_sr[0];
  assign b       = b_sr[0];
  assign d       = a ^ b ^ bw;
  assign bw_next = (~a & b) | (~(a ^ b) & bw);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status outputs.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = accept ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, bit-serial datapath and result registers.
  // NOTE: the shift registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      bw     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      v_q    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr <= bus.A;
      b_sr <= bus.B;
      bw   <= bus.B_in;
      cnt  <= '0;
`ifdef SUB_OVERFLOW_EN
      // Sign bits are kept aside because a_sr/b_sr are consumed by the shift.
      a_msb <= bus.A[data_width-1];
      b_msb <= bus.B[data_width-1];
`endif
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= {d, d_sr[data_width-1:1]};
      bw   <= bw_next;
      cnt  <= cnt + 1'b1;
      if (last_bit) begin
        diff_q <= {d, d_sr[data_width-1:1]};
        bout_q <= bw_next;
`ifdef SUB_OVERFLOW_EN
        // d is the result MSB on the final bit; B_in plays no part in V.
        v_q <= (a_msb != b_msb) && (d != a_msb);
`endif
      end
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.Diff  = diff_q;
  assign bus.B_out = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.V     = v_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (default data_width = 8).
// Define SUB_OVERFLOW_EN at build time to also check the V output.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  serial_subtractor_if #(.data_width(W)) bus ();

  serial_subtractor #(.data_width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation with the operands scrambled right after acceptance.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] exp_d, input logic exp_bo, input logic exp_v);
    int n;
    logic [W-1:0] held;
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.B_in = bin;
    tick();
    bus.start = 1'b0; bus.A = ~a; bus.B = ~b; bus.B_in = ~bin;
    check("busy_after_accept", bus.busy, 1);
    held = bus.Diff;
    n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
      if (!bus.done) check("diff_hold_run", bus.Diff, held);
    end
    check("latency", n, 8);
    check("diff", bus.Diff, exp_d);
    check("b_out", bus.B_out, exp_bo);
    check("busy_in_done", bus.busy, 0);
`ifdef SUB_OVERFLOW_EN
    check("v", bus.V, exp_v);
`else
    if (exp_v) begin end
`endif
    tick();
    check("done_one_cycle", bus.done, 0);
    check("idle_busy", bus.busy, 0);
    check("diff_hold_idle", bus.Diff, exp_d);
  endtask

  initial begin
    int n;
    int dones;
    logic [W-1:0] got;

    rst = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.B_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_diff", bus.Diff, 0);
    check("rst_bout", bus.B_out, 0);
`ifdef SUB_OVERFLOW_EN
    check("rst_v", bus.V, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: A, B, B_in, Diff, B_out, V.
    run_op(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    run_op(8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1);

    // start re-pulsed at cycle 3 of RUN is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'h50; bus.B = 8'h20; bus.B_in = 1'b0;
    tick();
    bus.start = 1'b0;
    dones = 0; got = '0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) begin
        bus.start = 1'b1; bus.A = 8'hFF; bus.B = 8'h00; bus.B_in = 1'b1;
      end
      tick();
      if (i == 3) bus.start = 1'b0;
      if (bus.done) begin dones++; got = bus.Diff; end
    end
    check("ignored_start_dones", dones, 1);
    check("ignored_start_diff", got, 8'h30);

    // start held high: a result every 9 cycles, busy low only on done cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'h10; bus.B = 8'h01; bus.B_in = 1'b0;
    tick();
    for (int i = 1; i <= 26; i++) begin
      tick();
      check("b2b_done", bus.done, (i % 9) == 8);
      check("b2b_busy", bus.busy, (i % 9) != 8);
      if (bus.done) check("b2b_diff", bus.Diff, 8'h0F);
    end
    bus.start = 1'b0;
    tick();
    check("b2b_release_idle", bus.busy, 0);

    // Asynchronous reset at cycle 4 of RUN discards the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'h50; bus.B = 8'h20; bus.B_in = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_diff", bus.Diff, 0);
    check("arst_bout", bus.B_out, 0);
`ifdef SUB_OVERFLOW_EN
    check("arst_v", bus.V, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) dones++;
    end
    check("arst_no_done", dones, 0);
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait above never completes.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
